// File: rtl/layer_seq_pkg.sv
// Shared types and the fixed LeNet-style layer descriptor table for the layer sequencer.
package layer_seq_pkg;

    localparam int NUM_LAYERS_C = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_GAP    = 3'd4,
        S_FINISH = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        IMG   = 2'd0,
        BUF_A = 2'd1,
        BUF_B = 2'd2
    } buf_sel_e;

    typedef struct packed {
        buf_sel_e    src_sel;
        buf_sel_e    dst_sel;
        logic [31:0] data_size;
        logic [31:0] weight_off;
        logic [31:0] weight_size;
    } layer_desc_t;

    localparam layer_desc_t LAYER_DESC [NUM_LAYERS_C] = '{
        '{IMG,   BUF_A, 32'd1764, 32'd0,   32'd40},
        '{BUF_A, BUF_B, 32'd6400, 32'd0,   32'd0},
        '{BUF_B, BUF_A, 32'd1600, 32'd40,  32'd148},
        '{BUF_A, BUF_B, 32'd1296, 32'd188, 32'd0},
        '{BUF_B, BUF_A, 32'd324,  32'd188, 32'd3250}
    };

    function automatic logic range_ok(input logic [2:0] first, input logic [2:0] last,
                                      input int unsigned num_layers);
        return (first <= last) && (32'(last) < num_layers);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Launch/complete handshake and descriptor buses between the layer sequencer and the layer control unit.
interface layer_sequencer_if #(parameter int ADDR_W = 32);
    logic              cu_go;
    logic [2:0]        cu_layer_index;
    logic [ADDR_W-1:0] cu_data_address;
    logic [ADDR_W-1:0] cu_data_size;
    logic [ADDR_W-1:0] cu_weight_address;
    logic [ADDR_W-1:0] cu_weight_size;
    logic [ADDR_W-1:0] cu_result_address;
    logic              cu_done;

    modport master (
        output cu_go, cu_layer_index, cu_data_address, cu_data_size,
               cu_weight_address, cu_weight_size, cu_result_address,
        input  cu_done
    );

    modport slave (
        input  cu_go, cu_layer_index, cu_data_address, cu_data_size,
               cu_weight_address, cu_weight_size, cu_result_address,
        output cu_done
    );
endinterface

// File: rtl/layer_sequencer_desc_rom.sv
// Combinational layer index -> descriptor lookup with source/destination base-address selection.
module layer_desc_rom
    import layer_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [2:0]        layer_idx_i,
    input  logic [ADDR_W-1:0] image_base_i,
    input  logic [ADDR_W-1:0] weight_base_i,
    input  logic [ADDR_W-1:0] buf_a_base_i,
    input  logic [ADDR_W-1:0] buf_b_base_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [ADDR_W-1:0] data_size_o,
    output logic [ADDR_W-1:0] weight_addr_o,
    output logic [ADDR_W-1:0] weight_size_o,
    output logic [ADDR_W-1:0] result_addr_o
);

    layer_desc_t desc_s;

    function automatic logic [ADDR_W-1:0] sel_base(input buf_sel_e sel,
                                                   input logic [ADDR_W-1:0] img,
                                                   input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] r;
        case (sel)
            IMG:     r = img;
            BUF_A:   r = a;
            BUF_B:   r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Descriptor lookup; out-of-table indices yield an all-zero descriptor
    always_comb begin
        desc_s = '0;
        case (layer_idx_i)
            3'd0:    desc_s = LAYER_DESC[0];
            3'd1:    desc_s = LAYER_DESC[1];
            3'd2:    desc_s = LAYER_DESC[2];
            3'd3:    desc_s = LAYER_DESC[3];
            3'd4:    desc_s = LAYER_DESC[4];
            default: desc_s = '0;
        endcase
    end

    assign data_addr_o   = sel_base(desc_s.src_sel, image_base_i, buf_a_base_i, buf_b_base_i);
    assign result_addr_o = sel_base(desc_s.dst_sel, image_base_i, buf_a_base_i, buf_b_base_i);
    assign data_size_o   = ADDR_W'(desc_s.data_size);
    assign weight_size_o = ADDR_W'(desc_s.weight_size);
    assign weight_addr_o = weight_base_i + ADDR_W'(desc_s.weight_off);

endmodule

// File: rtl/layer_sequencer.sv
// Network-level layer scheduler driving the layer control unit; optional run-cycle counter under LAYER_SEQ_PERF_EN.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_LAYERS = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        first_layer,
    input  logic [2:0]        last_layer,
    input  logic [ADDR_W-1:0] image_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] buf_a_base,
    input  logic [ADDR_W-1:0] buf_b_base,
    output logic              busy,
    output logic              run_done,
    output logic              run_aborted,
    output logic              cfg_error,
    output logic [2:0]        cur_layer,
    output logic [ADDR_W-1:0] result_base,
`ifdef LAYER_SEQ_PERF_EN
    output logic [31:0]       run_cycles,
`endif
    layer_sequencer_if.master cu
);

    seq_state_e        state_q, state_d;
    logic [2:0]        cur_layer_q, cur_layer_d, last_q, last_d, idx_q, idx_d;
    logic              abort_pend_q, abort_pend_d, busy_q, busy_d, go_q, go_d;
    logic              run_done_q, run_done_d, run_aborted_q, run_aborted_d;
    logic              cfg_error_q, cfg_error_d, accept_s, abort_now_s;
    logic [ADDR_W-1:0] result_base_q, result_base_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d, dsize_q, dsize_d, waddr_q, waddr_d;
    logic [ADDR_W-1:0] wsize_q, wsize_d, raddr_q, raddr_d;
    logic [ADDR_W-1:0] rom_daddr_s, rom_dsize_s, rom_waddr_s, rom_wsize_s, rom_raddr_s;

    layer_desc_rom #(.ADDR_W(ADDR_W)) u_rom (
        .layer_idx_i   (cur_layer_q),
        .image_base_i  (image_base),
        .weight_base_i (weight_base),
        .buf_a_base_i  (buf_a_base),
        .buf_b_base_i  (buf_b_base),
        .data_addr_o   (rom_daddr_s),
        .data_size_o   (rom_dsize_s),
        .weight_addr_o (rom_waddr_s),
        .weight_size_o (rom_wsize_s),
        .result_addr_o (rom_raddr_s)
    );

    assign abort_now_s = abort | abort_pend_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        cur_layer_d   = cur_layer_q;
        last_d        = last_q;
        idx_d         = idx_q;
        abort_pend_d  = abort_pend_q | ((state_q != S_IDLE) & abort);
        busy_d        = busy_q;
        go_d          = 1'b0;
        run_done_d    = 1'b0;
        run_aborted_d = 1'b0;
        cfg_error_d   = 1'b0;
        accept_s      = 1'b0;
        result_base_d = result_base_q;
        daddr_d       = daddr_q;
        dsize_d       = dsize_q;
        waddr_d       = waddr_q;
        wsize_d       = wsize_q;
        raddr_d       = raddr_q;
        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    if (range_ok(first_layer, last_layer, NUM_LAYERS)) begin
                        accept_s    = 1'b1;
                        cur_layer_d = first_layer;
                        last_d      = last_layer;
                        busy_d      = 1'b1;
                        state_d     = S_LOAD;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort_now_s) begin
                    state_d       = S_FINISH;
                    busy_d        = 1'b0;
                    run_aborted_d = 1'b1;
                    result_base_d = raddr_q;
                end else begin
                    idx_d   = cur_layer_q;
                    daddr_d = rom_daddr_s;
                    dsize_d = rom_dsize_s;
                    waddr_d = rom_waddr_s;
                    wsize_d = rom_wsize_s;
                    raddr_d = rom_raddr_s;
                    go_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (cu.cu_done) begin
                    if (abort_now_s || (cur_layer_q == last_q)) begin
                        state_d       = S_FINISH;
                        busy_d        = 1'b0;
                        run_aborted_d = abort_now_s;
                        run_done_d    = ~abort_now_s;
                        result_base_d = raddr_q;
                    end else begin
                        cur_layer_d = cur_layer_q + 3'd1;
                        state_d     = S_GAP;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (abort_now_s) begin
                    state_d       = S_FINISH;
                    busy_d        = 1'b0;
                    run_aborted_d = 1'b1;
                    result_base_d = raddr_q;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                abort_pend_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cur_layer_q   <= 3'd0;
            last_q        <= 3'd0;
            idx_q         <= 3'd0;
            abort_pend_q  <= 1'b0;
            busy_q        <= 1'b0;
            go_q          <= 1'b0;
            run_done_q    <= 1'b0;
            run_aborted_q <= 1'b0;
            cfg_error_q   <= 1'b0;
            result_base_q <= '0;
            daddr_q       <= '0;
            dsize_q       <= '0;
            waddr_q       <= '0;
            wsize_q       <= '0;
            raddr_q       <= '0;
        end else begin
            state_q       <= state_d;
            cur_layer_q   <= cur_layer_d;
            last_q        <= last_d;
            idx_q         <= idx_d;
            abort_pend_q  <= abort_pend_d;
            busy_q        <= busy_d;
            go_q          <= go_d;
            run_done_q    <= run_done_d;
            run_aborted_q <= run_aborted_d;
            cfg_error_q   <= cfg_error_d;
            result_base_q <= result_base_d;
            daddr_q       <= daddr_d;
            dsize_q       <= dsize_d;
            waddr_q       <= waddr_d;
            wsize_q       <= wsize_d;
            raddr_q       <= raddr_d;
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] run_cycles_q;

    // Busy-cycle counter: cleared on accepted start, saturating, held between runs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_cycles_q <= 32'd0;
        end else if (accept_s) begin
            run_cycles_q <= 32'd0;
        end else if (busy_q && (run_cycles_q != 32'hFFFF_FFFF)) begin
            run_cycles_q <= run_cycles_q + 32'd1;
        end else begin
            run_cycles_q <= run_cycles_q;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

    assign busy                 = busy_q;
    assign run_done             = run_done_q;
    assign run_aborted          = run_aborted_q;
    assign cfg_error            = cfg_error_q;
    assign cur_layer            = cur_layer_q;
    assign result_base          = result_base_q;
    assign cu.cu_go             = go_q;
    assign cu.cu_layer_index    = idx_q;
    assign cu.cu_data_address   = daddr_q;
    assign cu.cu_data_size      = dsize_q;
    assign cu.cu_weight_address = waddr_q;
    assign cu.cu_weight_size    = wsize_q;
    assign cu.cu_result_address = raddr_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: cu latency model, go/done monitor and a table-driven expectation model.
module tb_layer_sequencer;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstn, start, abort;
    logic [2:0]    first_layer, last_layer;
    logic [AW-1:0] image_base, weight_base, buf_a_base, buf_b_base;
    logic          busy, run_done, run_aborted, cfg_error;
    logic [2:0]    cur_layer;
    logic [AW-1:0] result_base;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0]   run_cycles;
`endif

    layer_sequencer_if #(.ADDR_W(AW)) cu_if ();

    layer_sequencer #(.ADDR_W(AW), .NUM_LAYERS(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .first_layer(first_layer), .last_layer(last_layer),
        .image_base(image_base), .weight_base(weight_base),
        .buf_a_base(buf_a_base), .buf_b_base(buf_b_base),
        .busy(busy), .run_done(run_done), .run_aborted(run_aborted),
        .cfg_error(cfg_error), .cur_layer(cur_layer), .result_base(result_base),
`ifdef LAYER_SEQ_PERF_EN
        .run_cycles(run_cycles),
`endif
        .cu(cu_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // cu model: done pulse lat cycles after go
    int lat = 20;
    int cnt = 0;
    always @(posedge clk) begin
        cu_if.cu_done <= 1'b0;
        if (!rstn)                 cnt <= 0;
        else if (cu_if.cu_go)      cnt <= lat;
        else if (cnt == 1) begin   cnt <= 0; cu_if.cu_done <= 1'b1; end
        else if (cnt > 1)          cnt <= cnt - 1;
    end

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] da, ds, wa, ws, ra;
        logic [31:0] gap;
    } go_ev_t;

    go_ev_t ev [128];
    int go_cnt = 0, done_cnt = 0, abt_cnt = 0, cfg_cnt = 0, busy_cyc = 0, cyc = 0, last_done = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cu_if.cu_done) last_done <= cyc;
        if (cu_if.cu_go && go_cnt < 128) begin
            ev[go_cnt] <= '{cu_if.cu_layer_index, cu_if.cu_data_address, cu_if.cu_data_size,
                            cu_if.cu_weight_address, cu_if.cu_weight_size, cu_if.cu_result_address,
                            32'(cyc - last_done)};
        end
        if (cu_if.cu_go) go_cnt <= go_cnt + 1;
        if (run_done)    done_cnt <= done_cnt + 1;
        if (run_aborted) abt_cnt <= abt_cnt + 1;
        if (cfg_error)   cfg_cnt <= cfg_cnt + 1;
        if (busy)        busy_cyc <= busy_cyc + 1;
    end

    // Reference tables: layer i writes A when even, B when odd; reads the previous layer's output
    int unsigned dsz  [5] = '{1764, 6400, 1600, 1296, 324};
    int unsigned woff [5] = '{0, 0, 40, 188, 188};
    int unsigned wsz  [5] = '{40, 0, 148, 0, 3250};

    function automatic logic [31:0] dst_addr(int i);
        return (i % 2 == 0) ? buf_a_base : buf_b_base;
    endfunction

    function automatic logic [31:0] src_addr(int i);
        return (i == 0) ? image_base : dst_addr(i - 1);
    endfunction

    int snap_go, snap_done, snap_abt, snap_cfg, snap_busy;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        snap_go = go_cnt; snap_done = done_cnt; snap_abt = abt_cnt;
        snap_cfg = cfg_cnt; snap_busy = busy_cyc;
    endtask

    task automatic randomize_bases();
        image_base  = $urandom;
        weight_base = $urandom;
        buf_a_base  = $urandom;
        buf_b_base  = $urandom;
    endtask

    task automatic start_run(input int f, input int l);
        first_layer = 3'(f);
        last_layer  = 3'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_go(input int n);
        for (int c = 0; c < 3000; c++) begin
            if (go_cnt >= n) break;
            tick();
        end
        check("go_reached", 64'(go_cnt >= n), 64'd1);
    endtask

    task automatic wait_end();
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt + abt_cnt != snap_done + snap_abt) break;
            tick();
        end
        check("run_ends", 64'(done_cnt + abt_cnt - snap_done - snap_abt), 64'd1);
        tick();
        tick();
    endtask

    task automatic check_layers(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            int i = f + k;
            go_ev_t e = ev[snap_go + k];
            check("layer_index", 64'(e.idx), 64'(i));
            check("data_addr",   64'(e.da), 64'(src_addr(i)));
            check("data_size",   64'(e.ds), 64'(dsz[i]));
            check("weight_addr", 64'(e.wa), 64'(32'(weight_base + woff[i])));
            check("weight_size", 64'(e.ws), 64'(wsz[i]));
            check("result_addr", 64'(e.ra), 64'(dst_addr(i)));
            if (k > 0) check("done_to_go_gap", 64'(e.gap), 64'd3);
        end
    endtask

    task automatic check_run(input int f, input int n_go, input bit aborted, input int final_layer);
        check("go_count",     64'(go_cnt - snap_go), 64'(n_go));
        check("run_done_cnt", 64'(done_cnt - snap_done), aborted ? 64'd0 : 64'd1);
        check("aborted_cnt",  64'(abt_cnt - snap_abt), aborted ? 64'd1 : 64'd0);
        check("busy_end",     64'(busy), 64'd0);
        check("result_base",  64'(result_base), 64'(dst_addr(final_layer)));
        check_layers(f, n_go);
`ifdef LAYER_SEQ_PERF_EN
        check("run_cycles",   64'(run_cycles), 64'(busy_cyc - snap_busy));
`endif
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        first_layer = 3'd0; last_layer = 3'd0;
        image_base = 32'h0; weight_base = 32'h0; buf_a_base = 32'h0; buf_b_base = 32'h0;
        repeat (3) tick();
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_go",     64'(cu_if.cu_go), 64'd0);
        check("rst_cur",    64'(cur_layer), 64'd0);
        check("rst_result", 64'(result_base), 64'd0);
        check("rst_daddr",  64'(cu_if.cu_data_address), 64'd0);
        rstn = 1'b1;
        tick();

        // Full run
        randomize_bases();
        weight_base = 32'h1000; buf_a_base = 32'h8000; lat = 20;
        snap(); start_run(0, 4); wait_end();
        check_run(0, 5, 1'b0, 4);
        check("L2_weight_addr", 64'(ev[snap_go + 2].wa), 64'h1028);
        check("L4_data_size",   64'(ev[snap_go + 4].ds), 64'd324);
        check("full_result",    64'(result_base), 64'h8000);

        // Partial run
        randomize_bases(); lat = $urandom_range(1, 30);
        snap(); start_run(2, 3); wait_end();
        check_run(2, 2, 1'b0, 3);
        check("partial_src_b", 64'(ev[snap_go].da), 64'(buf_b_base));

        // Illegal ranges
        snap(); start_run(3, 1); repeat (3) tick();
        start_run(0, 5); repeat (3) tick();
        check("cfg_err_cnt", 64'(cfg_cnt - snap_cfg), 64'd2);
        check("cfg_no_go",   64'(go_cnt - snap_go), 64'd0);
        check("cfg_no_busy", 64'(busy_cyc - snap_busy), 64'd0);

        // Abort during WAIT of layer 1
        randomize_bases(); lat = 20;
        snap(); start_run(0, 4); wait_go(snap_go + 2);
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_end(); repeat (30) tick();
        check_run(0, 2, 1'b1, 1);

        // Abort coincident with cu_done of the last layer
        randomize_bases(); lat = $urandom_range(2, 25);
        snap(); start_run(0, 4); wait_go(snap_go + 5);
        for (int c = 0; c < 100; c++) begin
            if (cu_if.cu_done) break;
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        wait_end();
        check_run(0, 5, 1'b1, 4);

        // Abort in GAP after layer 0: no further issue
        randomize_bases(); lat = $urandom_range(2, 25);
        snap(); start_run(0, 4); wait_go(snap_go + 1);
        for (int c = 0; c < 100; c++) begin
            if (cu_if.cu_done) break;
            tick();
        end
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_end(); repeat (10) tick();
        check_run(0, 1, 1'b1, 0);

        // Reset during WAIT of layer 3, then a normal run
        randomize_bases(); lat = 20;
        snap(); start_run(0, 4); wait_go(snap_go + 4);
        repeat (5) tick();
        rstn = 1'b0; tick();
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_daddr", 64'(cu_if.cu_data_address), 64'd0);
        check("mid_rst_waddr", 64'(cu_if.cu_weight_address), 64'd0);
        check("mid_rst_dsize", 64'(cu_if.cu_data_size), 64'd0);
        check("mid_rst_raddr", 64'(cu_if.cu_result_address), 64'd0);
        check("mid_rst_idx",   64'(cu_if.cu_layer_index), 64'd0);
        rstn = 1'b1; tick();
        randomize_bases();
        snap(); start_run(0, 4); wait_end();
        check_run(0, 5, 1'b0, 4);

        // Randomized legal runs with an ignored start pulse mid-run
        for (int r = 0; r < 4; r++) begin
            int f, l;
            f = $urandom_range(0, 4);
            l = $urandom_range(f, 4);
            randomize_bases();
            if (r == 0) weight_base = 32'hFFFF_FFF0;
            lat = $urandom_range(1, 30);
            snap(); start_run(f, l);
            wait_go(snap_go + 1);
            start_run(0, 0);
            first_layer = 3'(f); last_layer = 3'(l);
            wait_end();
            check_run(f, l - f + 1, 1'b0, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Network-level scheduler sitting directly upstream of the layer control unit (cu).
- Launches the five LeNet-style layers in order (conv, max, conv, max, dense) by driving cu's go / layer_index / address / size inputs, then waits for cu's done.
- Owns the ping-pong activation-buffer assignment and per-layer weight-blob offsets.
- Presents a start/busy/done/abort handshake to host software.

Parameters:
- ADDR_W, 32, width of all address and size buses
- NUM_LAYERS, 5, number of layers in the descriptor table (indices 0..NUM_LAYERS-1)

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  host run request, sampled only in IDLE
- abort  in  1  host stop request; level or pulse
- first_layer  in  3  first layer to run, sampled with start
- last_layer  in  3  last layer to run, sampled with start
- image_base  in  ADDR_W  input image base address
- weight_base  in  ADDR_W  weight blob base address
- buf_a_base  in  ADDR_W  activation buffer A base address
- buf_b_base  in  ADDR_W  activation buffer B base address
- busy  out  1  run in progress
- run_done  out  1  one-cycle pulse when last_layer completes normally
- run_aborted  out  1  one-cycle pulse when a run ends because of abort
- cfg_error  out  1  one-cycle pulse when a start request is rejected
- cur_layer  out  3  layer currently issued or running
- result_base  out  ADDR_W  base address of the final layer's output
- cu_go  out  1  one-cycle launch pulse to cu
- cu_layer_index  out  3  to cu
- cu_data_address  out  ADDR_W  to cu
- cu_data_size  out  ADDR_W  to cu
- cu_weight_address  out  ADDR_W  to cu
- cu_weight_size  out  ADDR_W  to cu
- cu_result_address  out  ADDR_W  to cu
- cu_done  in  1  layer-complete pulse from cu

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State to IDLE.
  - All outputs 0: busy, run_done, run_aborted, cfg_error, cu_go, cur_layer, result_base, all cu_* buses.
  - Abort-pending flag cleared.
  - Reset mid-run is legal; cu is reset by the same rstn.
- Address/size outputs are registered. They are stable from the ISSUE cycle until cu_done.
- IDLE:
  - start=1 with first_layer<=last_layer and last_layer<NUM_LAYERS:
    - latch the range; cur_layer=first_layer; busy=1; go to LOAD.
  - start=1 with an illegal range: cfg_error pulses for 1 cycle; stay in IDLE.
  - start while busy: ignored.
- LOAD: register the descriptor for cur_layer onto the cu_* buses -> ISSUE.
- ISSUE: cu_go=1 for exactly 1 cycle -> WAIT.
- WAIT: hold until cu_done=1, then:
  - if abort is pending -> FINISH(aborted);
  - else if cur_layer==last -> FINISH(done);
  - else cur_layer+1 -> GAP.
- GAP: one idle cycle so cu is back in its idle state before the next go -> LOAD.
  - Minimum spacing from cu_done to the next cu_go is 3 cycles.
- FINISH:
  - run_done or run_aborted pulses 1 cycle.
  - result_base = result address of the final layer issued.
  - busy=0 -> IDLE.
- Abort:
  - Sampled in any non-IDLE state and latched as pending.
  - cu cannot be stopped mid-layer, so the current layer always completes.
  - Abort in LOAD or GAP suppresses the next issue: go directly to FINISH(aborted), with no cu_go.
  - Abort and cu_done in the same cycle: treated as aborted.
- Descriptor table (data src -> result dst, data_size, weight offset, weight_size):
  - L0: image -> A, 1764, 0, 40
  - L1: A -> B, 6400, 0, 0
  - L2: B -> A, 1600, 40, 148
  - L3: A -> B, 1296, 188, 0
  - L4: B -> A, 324, 188, 3250
- Address rules:
  - weight_address = weight_base + offset.
  - ADDR_W-bit modular addition; no overflow detection.
- cu_done while in IDLE/LOAD/ISSUE/GAP: ignored.

Optional Feature:
- Macro: LAYER_SEQ_PERF_EN
- Defined:
  - Adds port run_cycles (out, 32).
  - Counter clears on an accepted start and increments every busy cycle.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value after FINISH until the next accepted start; reset value 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package layer_seq_pkg holds:
  - the state enum;
  - a layer_desc_t struct (src_sel, dst_sel, data_size, weight_off, weight_size);
  - a LAYER_DESC constant array of NUM_LAYERS entries;
  - the buffer-select encoding (IMG, BUF_A, BUF_B).
- One natural sub-module, layer_desc_rom: combinational index -> layer_desc_t plus the base-address mux.

Test Plan:
- Full run: start, first=0, last=4, weight_base=0x1000, buf_a=0x8000; cu model returns done 20 cycles after go.
  - Expect exactly 5 cu_go pulses with layer_index 0..4.
  - L2 cu_weight_address=0x1028; L4 cu_data_size=324.
  - run_done once; result_base=0x8000.
- Partial run: first=2, last=3.
  - Expect 2 go pulses (layers 2, 3); L2 data from buf_b; result_base=buf_b_base.
- Illegal range: first=3, last=1, then first=0, last=5.
  - Expect a cfg_error pulse each time, no cu_go, busy stays 0.
- Abort during WAIT of layer 1: layer 1 done is accepted, no further go, run_aborted=1, run_done never asserts.
- Abort coincident with cu_done of the last layer: run_aborted pulses, not run_done.
- Reset asserted in WAIT of layer 3: next cycle busy=0, all cu_* buses 0; a new start works normally.
- With LAYER_SEQ_PERF_EN defined: run_cycles equals the measured busy-cycle count.
